// File: rtl/input_port_unit_pkg.sv
// Shared definitions for the mesh router input port: channel indices,
// flit field offsets, route FSM encodings and the XY route function.
package input_port_unit_pkg;

  localparam int CHANNELS = 5;
  localparam int COORD_W  = 4;
  localparam int PORT_W   = 3;

  localparam logic [PORT_W-1:0] PORT_LOCAL = 3'd0;
  localparam logic [PORT_W-1:0] PORT_NORTH = 3'd1;
  localparam logic [PORT_W-1:0] PORT_EAST  = 3'd2;
  localparam logic [PORT_W-1:0] PORT_SOUTH = 3'd3;
  localparam logic [PORT_W-1:0] PORT_WEST  = 3'd4;

  // Field positions counted down from the flit MSB (bit W-n).
  localparam int FLD_HEAD   = 1;
  localparam int FLD_TAIL   = 2;
  localparam int FLD_DEST_X = 3;
  localparam int FLD_DEST_Y = 7;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ROUTED = 1'b1
  } route_state_e;

  // Dimension-ordered routing: resolve X first, then Y, else eject locally.
  function automatic logic [PORT_W-1:0] xy_route(
    input logic [COORD_W-1:0] dest_x,
    input logic [COORD_W-1:0] dest_y,
    input logic [COORD_W-1:0] my_x,
    input logic [COORD_W-1:0] my_y
  );
    if (dest_x > my_x)      return PORT_EAST;
    else if (dest_x < my_x) return PORT_WEST;
    else if (dest_y > my_y) return PORT_NORTH;
    else if (dest_y < my_y) return PORT_SOUTH;
    else                    return PORT_LOCAL;
  endfunction

endpackage

// File: rtl/input_port_unit_flit_fifo.sv
// Small flit FIFO with a combinational head view; push and pop may
// coincide, including when full.
module input_port_unit_flit_fifo #(
  parameter int P_DEPTH      = 4,
  parameter int P_FLIT_WIDTH = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    push,
  input  logic                    pop,
  input  logic [P_FLIT_WIDTH-1:0] data_in,
  output logic                    full,
  output logic                    empty,
  output logic [P_FLIT_WIDTH-1:0] head
);

  localparam int AW = $clog2(P_DEPTH);
  localparam int CW = $clog2(P_DEPTH + 1);

  logic [P_FLIT_WIDTH-1:0] mem [P_DEPTH];
  logic [AW-1:0]           wr_ptr_reg;
  logic [AW-1:0]           rd_ptr_reg;
  logic [CW-1:0]           count_reg;
  logic [CW-1:0]           count_next;

  assign full  = (count_reg == CW'(P_DEPTH));
  assign empty = (count_reg == '0);
  assign head  = mem[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr_reg] <= data_in;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/input_port_unit.sv
// Mesh router input port: buffers flits, XY-routes each packet head and
// presents a one-hot request to switch allocation; dequeues on grant.
module input_port_unit
  import input_port_unit_pkg::*;
#(
  parameter int P_ROUTER_ID  = 0,
  parameter int P_X          = 0,
  parameter int P_Y          = 0,
  parameter int P_DEPTH      = 4,
  parameter int P_FLIT_WIDTH = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    flit_in_valid,
  input  logic [P_FLIT_WIDTH-1:0] flit_in,
  output logic                    credit_out,
  input  logic [CHANNELS-1:0]     out_avail,
  output logic                    enable,
  output logic [CHANNELS-1:0]     request,
  input  logic                    grant,
  output logic [P_FLIT_WIDTH-1:0] flit_out,
  output logic                    flit_out_valid,
  output logic                    error
);

  localparam logic [COORD_W-1:0] MY_X = COORD_W'(P_X);
  localparam logic [COORD_W-1:0] MY_Y = COORD_W'(P_Y);

  // The router id only tags the instance for debug; no logic depends on it.
  if (P_ROUTER_ID < 0) begin : g_invalid_router_id
  end

  route_state_e            state_reg, state_next;
  logic [PORT_W-1:0]       route_reg, route_next;
  logic                    credit_reg;
  logic                    error_reg;

  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [P_FLIT_WIDTH-1:0] fifo_head;
  logic                    is_head, is_tail;
  logic [COORD_W-1:0]      dest_x, dest_y;
  logic                    deq, drop_head, overflow;

  assign is_head = fifo_head[P_FLIT_WIDTH-FLD_HEAD];
  assign is_tail = fifo_head[P_FLIT_WIDTH-FLD_TAIL];
  assign dest_x  = fifo_head[P_FLIT_WIDTH-FLD_DEST_X -: COORD_W];
  assign dest_y  = fifo_head[P_FLIT_WIDTH-FLD_DEST_Y -: COORD_W];

  assign enable   = (state_reg == ST_ROUTED) & ~fifo_empty & out_avail[route_reg];
  assign request  = enable ? (CHANNELS'(1) << route_reg) : '0;
  assign deq      = enable & grant;
  assign fifo_pop = deq | drop_head;
  // A full FIFO still accepts a write when a pop frees a slot at the same edge.
  assign fifo_push = flit_in_valid & (~fifo_full | fifo_pop);
  assign overflow  = flit_in_valid & fifo_full & ~fifo_pop;

  assign flit_out       = fifo_head;
  assign flit_out_valid = deq;
  assign credit_out     = credit_reg;
  assign error          = error_reg;

  input_port_unit_flit_fifo #(
    .P_DEPTH      (P_DEPTH),
    .P_FLIT_WIDTH (P_FLIT_WIDTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .data_in (flit_in),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

  always_comb begin
    state_next = state_reg;
    route_next = route_reg;
    drop_head  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (is_head) begin
            route_next = xy_route(dest_x, dest_y, MY_X, MY_Y);
            state_next = ST_ROUTED;
          end else begin
            // Body flit without a head: discard it so the port cannot stall.
            drop_head = 1'b1;
          end
        end
      end
      ST_ROUTED: begin
        if (deq && is_tail) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg  <= ST_IDLE;
      route_reg  <= '0;
      credit_reg <= 1'b0;
      error_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      route_reg  <= route_next;
      credit_reg <= deq;
      if (overflow || drop_head) error_reg <= 1'b1;
    end
  end

endmodule
